// File: rtl/solver_dispatch_if.sv
// Host-side job and result channels of the solver dispatcher.
//
// Handshake rule for both channels: a beat transfers on a rising clock edge
// where valid and ready are both high. The sender keeps valid and its payload
// steady until that edge. The receiver may raise or lower ready at any time.
interface solver_dispatch_if #(
    parameter int LIMB_BITS = 32,
    parameter int ID_BITS   = 16
);
    logic                 job_valid;
    logic                 job_ready;
    logic [ID_BITS-1:0]   job_id;
    logic [LIMB_BITS-1:0] job_cre;
    logic [LIMB_BITS-1:0] job_cim;
    logic                 job_last;

    logic                 res_valid;
    logic                 res_ready;
    logic [ID_BITS-1:0]   res_id;
    logic [15:0]          res_count;

    // Host side: produces jobs, consumes results.
    modport master (
        output job_valid, job_id, job_cre, job_cim, job_last, res_ready,
        input  job_ready, res_valid, res_id, res_count
    );

    // Dispatcher side: consumes jobs, produces results.
    modport slave (
        input  job_valid, job_id, job_cre, job_cim, job_last, res_ready,
        output job_ready, res_valid, res_id, res_count
    );
endinterface

// File: rtl/solver_dispatch.sv
// Solver dispatcher: streams job operands into the lowest-index idle solver,
// starts it, and returns finished results to the host through a round-robin
// arbiter. Dispatch and result return run independently of each other.
module solver_dispatch #(
    parameter int NUM_SOLVERS     = 4,
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_BITS       = 32,
    parameter int ID_BITS         = 16
) (
    input  logic                         clock,
    input  logic                         reset,

    input  logic                         cfg_num_limbs_en,
    input  logic [LIMB_INDEX_BITS-1:0]   cfg_num_limbs,
    input  logic                         cfg_iter_lim_en,
    input  logic [15:0]                  cfg_iter_lim,

    solver_dispatch_if.slave             host,

    output logic [LIMB_INDEX_BITS-1:0]   slv_wr_ind,
    output logic [LIMB_BITS-1:0]         slv_wr_data_re,
    output logic [LIMB_BITS-1:0]         slv_wr_data_im,
    output logic [NUM_SOLVERS-1:0]       slv_wr_real_en,
    output logic [NUM_SOLVERS-1:0]       slv_wr_imag_en,
    output logic [NUM_SOLVERS-1:0]       slv_wr_num_limbs_en,
    output logic [NUM_SOLVERS-1:0]       slv_wr_iter_lim_en,
    output logic [LIMB_INDEX_BITS-1:0]   slv_num_limbs,
    output logic [15:0]                  slv_iter_lim,
    output logic [NUM_SOLVERS-1:0]       slv_start,
    input  logic [NUM_SOLVERS-1:0]       slv_out_ready,
    input  logic [16*NUM_SOLVERS-1:0]    slv_iteration_count,

    output logic                         err_len,
    output logic [1:0]                   dbg_state
);

    localparam int IDX_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

    typedef enum logic [1:0] {
        ST_SEL   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2
    } state_t;

    state_t                       state;
    logic [IDX_W-1:0]             sel_idx;
    logic                         cfg_pulse;
    logic                         first_beat;
    logic                         job_ready_q;
    logic [LIMB_INDEX_BITS-1:0]   beat_cnt;
    logic                         err_q;
    logic                         start_d;
    logic [IDX_W-1:0]             start_idx;
    logic [ID_BITS-1:0]           tag [NUM_SOLVERS];

    logic [LIMB_INDEX_BITS-1:0]   num_limbs_sh;
    logic [15:0]                  iter_lim_sh;

    logic [NUM_SOLVERS-1:0]       busy;
    logic [NUM_SOLVERS-1:0]       armed;
    logic [IDX_W-1:0]             rr_ptr;
    logic [IDX_W-1:0]             grant;
    logic                         res_valid_q;
    logic [ID_BITS-1:0]           res_id_q;
    logic [15:0]                  res_count_q;

    logic [NUM_SOLVERS-1:0]       one_hot_base;
    logic [NUM_SOLVERS-1:0]       sel_oh;
    logic [NUM_SOLVERS-1:0]       start_oh;
    logic [NUM_SOLVERS-1:0]       grant_oh;
    logic [NUM_SOLVERS-1:0]       done;
    logic [LIMB_INDEX_BITS-1:0]   last_ind;
    logic                         accept;
    logic                         handshake;
    logic                         free_found;
    logic [IDX_W-1:0]             free_idx;
    logic                         rr_found;
    logic [IDX_W-1:0]             rr_idx;
    logic [15:0]                  slv_count [NUM_SOLVERS];

    // Unpack the flat iteration-count bus into one word per solver.
    for (genvar gi = 0; gi < NUM_SOLVERS; gi++) begin : g_count
        assign slv_count[gi] = slv_iteration_count[16*gi +: 16];
    end

    assign one_hot_base = {{(NUM_SOLVERS-1){1'b0}}, 1'b1};
    assign sel_oh       = one_hot_base << sel_idx;
    assign start_oh     = one_hot_base << start_idx;
    assign grant_oh     = one_hot_base << grant;
    assign last_ind     = num_limbs_sh - {{(LIMB_INDEX_BITS-1){1'b0}}, 1'b1};

    // Writes and starts are suppressed while reset is high so a job cut off
    // by reset never leaves a partial write or start behind.
    assign accept    = job_ready_q && host.job_valid && !reset;
    assign handshake = res_valid_q && host.res_ready;

    // A solver's done flag is ignored until it has been armed, which masks a
    // completion flag left over from its previous job.
    assign done = busy & armed & slv_out_ready;

    assign host.job_ready      = job_ready_q;
    assign host.res_valid      = res_valid_q;
    assign host.res_id         = res_id_q;
    assign host.res_count      = res_count_q;

    assign slv_wr_ind          = beat_cnt;
    assign slv_wr_data_re      = accept ? host.job_cre : '0;
    assign slv_wr_data_im      = accept ? host.job_cim : '0;
    assign slv_wr_real_en      = accept ? sel_oh : '0;
    assign slv_wr_imag_en      = accept ? sel_oh : '0;
    assign slv_wr_num_limbs_en = (cfg_pulse && !reset) ? sel_oh : '0;
    assign slv_wr_iter_lim_en  = (cfg_pulse && !reset) ? sel_oh : '0;
    assign slv_start           = (state == ST_START && !reset) ? sel_oh : '0;
    assign slv_num_limbs       = num_limbs_sh;
    assign slv_iter_lim        = iter_lim_sh;
    assign err_len             = err_q;
    assign dbg_state           = state;

    // Lowest-index idle solver; the descending scan lets index 0 win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Round-robin pick among done solvers, scanning upward from rr_ptr.
    always_comb begin
        logic [IDX_W-1:0] cand;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            if (int'(rr_ptr) + k >= NUM_SOLVERS) begin
                cand = IDX_W'(int'(rr_ptr) + k - NUM_SOLVERS);
            end else begin
                cand = IDX_W'(int'(rr_ptr) + k);
            end
            if (!rr_found && done[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Shadow configuration registers, written whenever their enable is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            num_limbs_sh <= '0;
            iter_lim_sh  <= '0;
        end else begin
            if (cfg_num_limbs_en) num_limbs_sh <= cfg_num_limbs;
            if (cfg_iter_lim_en)  iter_lim_sh  <= cfg_iter_lim;
        end
    end

    // Dispatch FSM: pick an idle solver, stream the job into it, start it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_SEL;
            sel_idx     <= '0;
            cfg_pulse   <= 1'b0;
            first_beat  <= 1'b0;
            job_ready_q <= 1'b0;
            beat_cnt    <= '0;
            err_q       <= 1'b0;
            start_d     <= 1'b0;
            start_idx   <= '0;
            for (int i = 0; i < NUM_SOLVERS; i++) tag[i] <= '0;
        end else begin
            cfg_pulse <= 1'b0;
            start_d   <= (state == ST_START);
            start_idx <= sel_idx;
            case (state)
                ST_SEL: begin
                    if (free_found) begin
                        sel_idx     <= free_idx;
                        state       <= ST_LOAD;
                        cfg_pulse   <= 1'b1;
                        first_beat  <= 1'b1;
                        job_ready_q <= 1'b1;
                        beat_cnt    <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        first_beat <= 1'b0;
                        if (first_beat) tag[sel_idx] <= host.job_id;
                        if (host.job_last) begin
                            state       <= ST_START;
                            job_ready_q <= 1'b0;
                            beat_cnt    <= '0;
                            if (beat_cnt != last_ind) err_q <= 1'b1;
                        end else begin
                            // Wraps naturally at 2^LIMB_INDEX_BITS.
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    state <= ST_SEL;
                end
                default: begin
                    state <= ST_SEL;
                end
            endcase
        end
    end

    // Solver occupancy and result arbiter; a grant holds until the host takes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy        <= '0;
            armed       <= '0;
            rr_ptr      <= '0;
            grant       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_count_q <= '0;
        end else begin
            busy  <= (busy  & ~(handshake ? grant_oh : '0))
                   | ((state == ST_START) ? sel_oh : '0);
            armed <= (armed & ~(handshake ? grant_oh : '0))
                   | (start_d ? start_oh : '0);
            if (res_valid_q) begin
                if (host.res_ready) begin
                    res_valid_q <= 1'b0;
                    if (grant == IDX_W'(NUM_SOLVERS - 1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= grant + IDX_W'(1);
                    end
                end
            end else if (rr_found) begin
                res_valid_q <= 1'b1;
                grant       <= rr_idx;
                res_id_q    <= tag[rr_idx];
                res_count_q <= slv_count[rr_idx];
            end
        end
    end

endmodule

// File: tb/tb_solver_dispatch.sv
// Directed bench for solver_dispatch: a table of single-job vectors plus
// hand-written sequences for saturation, round-robin return and mid-job reset.
module tb_solver_dispatch;

    localparam int N   = 4;
    localparam int LIB = 6;
    localparam int LB  = 32;
    localparam int IDB = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic             cfg_num_limbs_en;
    logic [LIB-1:0]   cfg_num_limbs;
    logic             cfg_iter_lim_en;
    logic [15:0]      cfg_iter_lim;
    logic [LIB-1:0]   slv_wr_ind;
    logic [LB-1:0]    slv_wr_data_re;
    logic [LB-1:0]    slv_wr_data_im;
    logic [N-1:0]     slv_wr_real_en;
    logic [N-1:0]     slv_wr_imag_en;
    logic [N-1:0]     slv_wr_num_limbs_en;
    logic [N-1:0]     slv_wr_iter_lim_en;
    logic [LIB-1:0]   slv_num_limbs;
    logic [15:0]      slv_iter_lim;
    logic [N-1:0]     slv_start;
    logic [N-1:0]     slv_out_ready;
    logic [16*N-1:0]  slv_iteration_count;
    logic             err_len;
    logic [1:0]       dbg_state;

    solver_dispatch_if #(.LIMB_BITS(LB), .ID_BITS(IDB)) host ();

    solver_dispatch #(
        .NUM_SOLVERS(N), .LIMB_INDEX_BITS(LIB), .LIMB_BITS(LB), .ID_BITS(IDB)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .cfg_num_limbs_en    (cfg_num_limbs_en),
        .cfg_num_limbs       (cfg_num_limbs),
        .cfg_iter_lim_en     (cfg_iter_lim_en),
        .cfg_iter_lim        (cfg_iter_lim),
        .host                (host),
        .slv_wr_ind          (slv_wr_ind),
        .slv_wr_data_re      (slv_wr_data_re),
        .slv_wr_data_im      (slv_wr_data_im),
        .slv_wr_real_en      (slv_wr_real_en),
        .slv_wr_imag_en      (slv_wr_imag_en),
        .slv_wr_num_limbs_en (slv_wr_num_limbs_en),
        .slv_wr_iter_lim_en  (slv_wr_iter_lim_en),
        .slv_num_limbs       (slv_num_limbs),
        .slv_iter_lim        (slv_iter_lim),
        .slv_start           (slv_start),
        .slv_out_ready       (slv_out_ready),
        .slv_iteration_count (slv_iteration_count),
        .err_len             (err_len),
        .dbg_state           (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    // Expected results, {res_id, res_count}, in the order they must appear.
    logic [31:0] exp_q[$];

    typedef struct {
        int          nl;
        int          beats;
        int          stall_at;
        logic [15:0] id;
        logic [15:0] cnt;
        logic        err;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_re(input logic [15:0] id, input int b);
        return {id, 8'hC3, 8'(b)};
    endfunction

    function automatic logic [31:0] beat_im(input logic [15:0] id, input int b);
        return {~id, 8'h5A, 8'(b)};
    endfunction

    task automatic idle_job_inputs();
        host.job_valid   = 1'b0;
        host.job_id      = '0;
        host.job_cre     = '0;
        host.job_cim     = '0;
        host.job_last    = 1'b0;
        host.res_ready   = 1'b0;
        cfg_num_limbs_en = 1'b0;
        cfg_num_limbs    = '0;
        cfg_iter_lim_en  = 1'b0;
        cfg_iter_lim     = '0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        idle_job_inputs();
        slv_out_ready       = '0;
        slv_iteration_count = '0;
        @(negedge clock);
        @(negedge clock);
    endtask

    // Leave reset while writing the shadow config in the same cycle.
    task automatic release_cfg(input int nl, input int il);
        reset            = 1'b0;
        cfg_num_limbs_en = 1'b1;
        cfg_num_limbs    = 6'(nl);
        cfg_iter_lim_en  = 1'b1;
        cfg_iter_lim     = 16'(il);
        @(negedge clock);
        cfg_num_limbs_en = 1'b0;
        cfg_iter_lim_en  = 1'b0;
    endtask

    task automatic wait_ready(input int limit, output logic got);
        got = 1'b0;
        for (int k = 0; k < limit; k++) begin
            #1;
            if (host.job_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic send_job(input int slot, input int nbeats, input int stall_at,
                            input logic [15:0] id, input int nl, input int il,
                            input logic exp_err, input string nm);
        logic got;
        logic [N-1:0] oh;
        oh = N'(1) << slot;
        wait_ready(20, got);
        check({nm, " ready"}, 64'(got), 64'd1);
        if (!got) return;
        check({nm, " nl_en"}, 64'(slv_wr_num_limbs_en), 64'(oh));
        check({nm, " il_en"}, 64'(slv_wr_iter_lim_en), 64'(oh));
        check({nm, " num_limbs"}, 64'(slv_num_limbs), 64'(nl));
        check({nm, " iter_lim"}, 64'(slv_iter_lim), 64'(il));
        for (int b = 0; b < nbeats; b++) begin
            if (b > 0) @(negedge clock);
            if (b == stall_at) begin
                host.job_valid = 1'b0;
                #1;
                check($sformatf("%s stall en b%0d", nm, b),
                      64'({slv_wr_real_en, slv_wr_imag_en}), 64'd0);
                check($sformatf("%s stall ind b%0d", nm, b), 64'(slv_wr_ind), 64'(6'(b)));
                @(negedge clock);
            end
            host.job_valid = 1'b1;
            host.job_id    = (b == 0) ? id : 16'hDEAD;
            host.job_cre   = beat_re(id, b);
            host.job_cim   = beat_im(id, b);
            host.job_last  = (b == nbeats - 1);
            #1;
            check($sformatf("%s wr_en b%0d", nm, b),
                  64'({slv_wr_real_en, slv_wr_imag_en}), 64'({oh, oh}));
            check($sformatf("%s ind b%0d", nm, b), 64'(slv_wr_ind), 64'(6'(b)));
            check($sformatf("%s data b%0d", nm, b),
                  {slv_wr_data_re, slv_wr_data_im}, {beat_re(id, b), beat_im(id, b)});
        end
        @(negedge clock);
        host.job_valid = 1'b0;
        host.job_last  = 1'b0;
        #1;
        check({nm, " start"}, 64'(slv_start), 64'(oh));
        check({nm, " ready low"}, 64'(host.job_ready), 64'd0);
        check({nm, " err_len"}, 64'(err_len), 64'(exp_err));
        @(negedge clock);
        #1;
        check({nm, " start 1cyc"}, 64'(slv_start), 64'd0);
    endtask

    task automatic finish_solver(input int slot, input logic [15:0] cnt, input logic [15:0] id);
        slv_iteration_count[16*slot +: 16] = cnt;
        slv_out_ready[slot] = 1'b1;
        exp_q.push_back({id, cnt});
    endtask

    // Wait for a result, check it against the scoreboard, optionally hold it
    // with res_ready low, then take it.
    task automatic take_result(input string nm, input int hold);
        logic        got;
        logic [31:0] exp;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (host.res_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check({nm, " res_valid"}, 64'(got), 64'd1);
        if (!got) return;
        if (exp_q.size() == 0) begin
            check({nm, " expected entry"}, 64'd0, 64'd1);
            return;
        end
        exp = exp_q.pop_front();
        check({nm, " res"}, 64'({host.res_id, host.res_count}), 64'(exp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            #1;
            check($sformatf("%s hold%0d", nm, h),
                  64'({host.res_valid, host.res_id, host.res_count}), 64'({1'b1, exp}));
        end
        host.res_ready = 1'b1;
        @(negedge clock);
        host.res_ready = 1'b0;
        #1;
        check({nm, " valid drop"}, 64'(host.res_valid), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic got;
        reset = 1'b1;
        idle_job_inputs();
        slv_out_ready       = '0;
        slv_iteration_count = '0;

        vecs[0] = '{nl: 4, beats: 4, stall_at: 2,  id: 16'h000A, cnt: 16'd37,   err: 1'b0};
        vecs[1] = '{nl: 4, beats: 3, stall_at: -1, id: 16'h001B, cnt: 16'd5,    err: 1'b1};
        vecs[2] = '{nl: 2, beats: 2, stall_at: 1,  id: 16'hBEEF, cnt: 16'hFFFF, err: 1'b0};
        vecs[3] = '{nl: 1, beats: 1, stall_at: -1, id: 16'h0001, cnt: 16'd0,    err: 1'b0};
        vecs[4] = '{nl: 3, beats: 5, stall_at: -1, id: 16'h7777, cnt: 16'd1234, err: 1'b1};

        // Single-job vectors, each on solver 0 after a fresh reset.
        for (int v = 0; v < 5; v++) begin
            apply_reset();
            #1;
            check($sformatf("v%0d reset state", v),
                  64'({dbg_state, host.job_ready, host.res_valid, err_len}), 64'd0);
            release_cfg(vecs[v].nl, 100 + 7 * v);
            send_job(0, vecs[v].beats, vecs[v].stall_at, vecs[v].id, vecs[v].nl,
                     100 + 7 * v, vecs[v].err, $sformatf("v%0d", v));
            finish_solver(0, vecs[v].cnt, vecs[v].id);
            take_result($sformatf("v%0d", v), 0);
            slv_out_ready = '0;
        end

        // Five jobs with four solvers: the fifth waits for a freed solver.
        apply_reset();
        release_cfg(1, 50);
        for (int j = 0; j < 4; j++) begin
            send_job(j, 1, -1, 16'(16'h20 + j), 1, 50, 1'b0, $sformatf("sat j%0d", j));
        end
        @(negedge clock);
        wait_ready(12, got);
        check("sat job4 blocked", 64'(got), 64'd0);
        finish_solver(2, 16'h0022, 16'h0022);
        take_result("sat free2", 0);
        slv_out_ready = '0;
        send_job(2, 1, -1, 16'h0024, 1, 50, 1'b0, "sat j4");

        // Round-robin return: 1 and 3 finish together, then 0 joins.
        apply_reset();
        release_cfg(1, 50);
        for (int j = 0; j < 4; j++) begin
            send_job(j, 1, -1, 16'(16'h30 + j), 1, 50, 1'b0, $sformatf("rr j%0d", j));
        end
        finish_solver(1, 16'd11, 16'h0031);
        finish_solver(3, 16'd33, 16'h0033);
        take_result("rr g1", 5);
        slv_out_ready[1] = 1'b0;
        finish_solver(0, 16'h0050, 16'h0030);
        take_result("rr g3", 0);
        take_result("rr g0", 0);
        slv_out_ready = '0;

        // Reset in the middle of loading a job.
        apply_reset();
        release_cfg(4, 100);
        wait_ready(20, got);
        check("mid ready", 64'(got), 64'd1);
        for (int b = 0; b < 2; b++) begin
            if (b > 0) @(negedge clock);
            host.job_valid = 1'b1;
            host.job_id    = 16'h0099;
            host.job_cre   = beat_re(16'h0099, b);
            host.job_cim   = beat_im(16'h0099, b);
            host.job_last  = 1'b0;
        end
        @(negedge clock);
        reset = 1'b1;
        host.job_cre = beat_re(16'h0099, 2);
        host.job_cim = beat_im(16'h0099, 2);
        #1;
        check("mid reset wr suppressed", 64'({slv_wr_real_en, slv_wr_imag_en}), 64'd0);
        @(negedge clock);
        idle_job_inputs();
        #1;
        check("mid reset handshakes", 64'({host.job_ready, host.res_valid}), 64'd0);
        check("mid reset enables",
              64'({slv_wr_real_en, slv_wr_imag_en, slv_wr_num_limbs_en,
                   slv_wr_iter_lim_en, slv_start}), 64'd0);
        check("mid reset ind/shadows",
              64'({slv_wr_ind, slv_num_limbs, slv_iter_lim}), 64'd0);
        check("mid reset state/err", 64'({dbg_state, err_len}), 64'd0);
        @(negedge clock);
        release_cfg(4, 100);
        send_job(0, 4, -1, 16'h0055, 4, 100, 1'b0, "post");
        finish_solver(0, 16'd77, 16'h0055);
        take_result("post", 0);
        slv_out_ready = '0;

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
